rmw_pipe_mem: RTL
=================

Name: rmw_pipe_mem

Overview:
- Parametrised, zero-stall read-modify-write pipeline over an internal 2^AW x DW dual-port synchronous memory.
  - Port 0 is the read port; port 1 is the write port.
- Accepts one command per clock: address, opcode and operand. Reads the word, applies the operation, writes the result back and reports it.
- Full hazard forwarding guarantees in-order read-after-write semantics per address.
- Successor to the fixed 8-bit/16-bit increment-only pipeline. Adds width/depth parameters, opcodes, valid/ready handshake and a hardware memory-clear FSM.

Parameters:
- DW, 16, data word width (>=2)
- AW, 8, address width; memory depth = 2^AW

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  command present this cycle
- in_ready  out  1  block accepts commands (RUN state)
- in_addr  in  AW  target word address
- in_op  in  2  00 INC (+1), 01 ADD operand, 10 SUB operand, 11 WRITE operand
- in_operand  in  DW  operand; ignored for INC
- res_valid  out  1  result of one command valid this cycle
- res_addr  out  AW  address of reported command
- res_data  out  DW  new value written for that command
- res_sat  out  1  saturation occurred (see Optional Feature)
- init_done  out  1  memory clear complete

Behaviour:
- Reset values: in_ready=0, res_valid=0, res_addr=0, res_data=0, res_sat=0, init_done=0. All stage valid bits=0, clear counter=0, FSM=INIT. Memory contents are not reset by rst; they are cleared by INIT.
- FSM INIT: write port writes 0 to address clr_cnt each cycle, clr_cnt increments.
  - After address 2^AW-1 is written, go to RUN on the next edge.
  - INIT lasts exactly 2^AW cycles after rst deasserts.
- FSM RUN: in_ready=1, init_done=1. RUN is held until rst.
- A command is accepted on a rising edge where in_valid && in_ready. in_valid while in_ready=0 is dropped, with no side effect. No backpressure in RUN.
- Pipeline stages:
  - S0: register the command; issue read address to port 0.
  - S1: memory data returns.
  - S2: forwarding mux selects the operand source; register it.
  - S3: compute; register result.
  - Write port then writes the S3 result (WE = S3 valid) on the following edge.
- Latency: a command accepted at edge N gives res_valid=1 with its res_addr/res_data during the cycle after edge N+3. Exactly one result per accepted command, in acceptance order.
- Forwarding rule: the old value used by command k equals memory as modified by every earlier accepted command to the same address.
  - Covers every in-flight distance (1, 2, 3, 4 cycles), including the write-back cycle racing the sync read.
  - Compare addresses only against valid stages; bubbles never forward.
  - When several stages match, the youngest older stage has priority.
- Arithmetic is modulo 2^DW:
  - INC = old+1
  - ADD = old+operand
  - SUB = old-operand
  - WRITE = operand
  - res_sat=0 always.
- Reset asserted mid-operation:
  - All outputs and valid bits clear immediately, asynchronously.
  - In-flight commands are discarded and never written.
  - INIT re-runs, so memory reads 0 afterwards.

Optional Feature:
- Macro RMW_SAT_EN.
- Defined: INC and ADD clamp at 2^DW-1; SUB clamps at 0. res_sat=1 with res_valid when a clamp occurred. The clamped value is the one written and forwarded.
- Undefined: wrap-around arithmetic; res_sat tied to 0.

Test Plan:
- Reset release, DW=16/AW=8 -> in_ready=0 for 256 cycles then 1. INC addr 0x05 -> res_data=0x0001, 4 cycles after acceptance.
- INC addr 0x10 on 4 consecutive cycles -> res_data 1,2,3,4 on consecutive cycles (distance-1 forwarding).
- INC addr 0x07, then 1/2/3/4-cycle bubbles before each next INC 0x07 -> results 1,2,3,4,5 (all forwarding distances plus plain memory read).
- WRITE 0x20=0xFFFF, ADD 0x21 by 3, INC 0x20 back-to-back -> res_data 0xFFFF, 0x0003, then 0x0000 (without macro) or 0xFFFF with res_sat=1 (with macro).
- WRITE 0x30=2, SUB 0x30 by 5 -> 0xFFFD (without macro) or 0x0000 with res_sat=1 (with macro).
- Accept 3 INCs to 0x40, assert rst 2 cycles later -> res_valid=0 immediately, no result emitted. After INIT, INC 0x40 -> 0x0001.

Source files
------------

// File: rtl/rmw_pipe_mem_if.sv
// Command/result bundle for rmw_pipe_mem.
// Handshake: a command transfers on a rising clk edge where in_valid && in_ready.
// in_ready is high only while the block is in RUN; commands offered while it is
// low are dropped. Results carry no ready: res_valid is a one-cycle strobe per
// accepted command, emitted in acceptance order. fsm_state mirrors the clear FSM
// (0 = INIT, 1 = RUN).
interface rmw_pipe_mem_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_op;
    logic [DW-1:0] in_operand;
    logic          res_valid;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_data;
    logic          res_sat;
    logic          init_done;
    logic          fsm_state;

    modport master (
        output in_valid, in_addr, in_op, in_operand,
        input  in_ready, res_valid, res_addr, res_data, res_sat, init_done, fsm_state
    );

    modport slave (
        input  in_valid, in_addr, in_op, in_operand,
        output in_ready, res_valid, res_addr, res_data, res_sat, init_done, fsm_state
    );
endinterface

// File: rtl/rmw_pipe_mem.sv
// Zero-stall read-modify-write pipeline over a 2^AW x DW dual-port sync memory.
// Stages: S0 command reg / read issue, S1 read data, S2 forwarded old value,
// S3 result (reported), then write-back; S4 remembers the word written on the
// last edge so a read racing that write still sees it.
// Optional macro RMW_SAT_EN: saturating INC/ADD/SUB with res_sat reporting;
// without it arithmetic wraps and res_sat is 0.
module rmw_pipe_mem #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input logic           clk,
    input logic           rst,
    rmw_pipe_mem_if.slave bus
);
    localparam logic [1:0]    OP_INC   = 2'b00;
    localparam logic [1:0]    OP_ADD   = 2'b01;
    localparam logic [1:0]    OP_SUB   = 2'b10;
    localparam logic [DW-1:0] ONE      = DW'(1);
    localparam logic [AW-1:0] CLR_LAST = '1;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;
    logic          init_we;
    logic          accept;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          s0_valid, s1_valid, s2_valid, s3_valid, s4_valid;
    logic [AW-1:0] s0_addr, s1_addr, s2_addr, s3_addr, s4_addr;
    logic [1:0]    s0_op, s1_op, s2_op;
    logic [DW-1:0] s0_operand, s1_operand, s2_operand;
    logic [DW-1:0] s2_old, s3_data, s4_data;
    logic          s3_sat;
    logic [DW-1:0] fwd_old;
    logic [DW-1:0] new_data;
    logic          new_sat;

    // Clear-FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clear-FSM next state: sweep every address with zero, then run forever.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        init_we     = 1'b0;
        case (state)
            ST_INIT: begin
                init_we     = 1'b1;
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (clr_cnt == CLR_LAST) state_nxt = ST_RUN;
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign accept        = bus.in_valid && (state == ST_RUN);
    assign bus.in_ready  = (state == ST_RUN);
    assign bus.init_done = (state == ST_RUN);
    assign bus.fsm_state = state;

    // Write port is owned by the clear sweep during INIT, by S3 otherwise.
    assign wr_en   = init_we || s3_valid;
    assign wr_addr = init_we ? clr_cnt : s3_addr;
    assign wr_data = init_we ? '0 : s3_data;

    // Memory write port (port 1); contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Memory read port (port 0): old data for the S0 command lands in S1.
    always_ff @(posedge clk) begin
        rd_data <= mem[s0_addr];
    end

    // Forwarding: youngest older in-flight write to the same address wins.
    always_comb begin
        fwd_old = rd_data;
        if (s2_valid && (s2_addr == s1_addr))      fwd_old = new_data;
        else if (s3_valid && (s3_addr == s1_addr)) fwd_old = s3_data;
        else if (s4_valid && (s4_addr == s1_addr)) fwd_old = s4_data;
    end

    // Operation unit on the S2 old value.
    always_comb begin
        new_data = s2_operand;
        new_sat  = 1'b0;
`ifdef RMW_SAT_EN
        case (s2_op)
            OP_INC, OP_ADD: begin
                logic [DW:0] sum_ext;
                sum_ext = {1'b0, s2_old} + {1'b0, (s2_op == OP_INC) ? ONE : s2_operand};
                if (sum_ext[DW]) begin
                    new_data = '1;
                    new_sat  = 1'b1;
                end else begin
                    new_data = sum_ext[DW-1:0];
                end
            end
            OP_SUB: begin
                if (s2_operand > s2_old) begin
                    new_data = '0;
                    new_sat  = 1'b1;
                end else begin
                    new_data = s2_old - s2_operand;
                end
            end
            default: new_data = s2_operand;
        endcase
`else
        case (s2_op)
            OP_INC:  new_data = s2_old + ONE;
            OP_ADD:  new_data = s2_old + s2_operand;
            OP_SUB:  new_data = s2_old - s2_operand;
            default: new_data = s2_operand;
        endcase
`endif
    end

    // Pipeline registers; reset discards every in-flight command at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0; s0_addr <= '0; s0_op <= '0; s0_operand <= '0;
            s1_valid <= 1'b0; s1_addr <= '0; s1_op <= '0; s1_operand <= '0;
            s2_valid <= 1'b0; s2_addr <= '0; s2_op <= '0; s2_operand <= '0; s2_old <= '0;
            s3_valid <= 1'b0; s3_addr <= '0; s3_data <= '0; s3_sat <= 1'b0;
            s4_valid <= 1'b0; s4_addr <= '0; s4_data <= '0;
        end else begin
            s0_valid   <= accept;
            s0_addr    <= bus.in_addr;
            s0_op      <= bus.in_op;
            s0_operand <= bus.in_operand;
            s1_valid   <= s0_valid;
            s1_addr    <= s0_addr;
            s1_op      <= s0_op;
            s1_operand <= s0_operand;
            s2_valid   <= s1_valid;
            s2_addr    <= s1_addr;
            s2_op      <= s1_op;
            s2_operand <= s1_operand;
            s2_old     <= fwd_old;
            s3_valid   <= s2_valid;
            s3_addr    <= s2_addr;
            s3_data    <= new_data;
            s3_sat     <= s2_valid && new_sat;
            s4_valid   <= s3_valid;
            s4_addr    <= s3_addr;
            s4_data    <= s3_data;
        end
    end

    assign bus.res_valid = s3_valid;
    assign bus.res_addr  = s3_addr;
    assign bus.res_data  = s3_data;
    assign bus.res_sat   = s3_sat;
endmodule
